// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder; master issues start+operands, slave returns busy/done/result.
interface serial_adder_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first: {cout,sum} = a+b+cin; WIDTH cycles busy, done pulses the cycle after.
// No backpressure: start is only honoured in IDLE, ignored while busy or done.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    logic             s_bit;
    logic             c_next;
    logic             last_bit;

    // Single full-adder cell on the current LSBs.
    assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
    assign c_next   = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res    <= '0;
            sum_q  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh   <= bus.a;
                        b_sh   <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        state  <= RUN;
                        busy_q <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_next;
                    res   <= {s_bit, res[WIDTH-1:1]};
                    if (last_bit) begin
                        // Counter is held on the final bit so it never wraps mid-operation.
                        sum_q  <= {s_bit, res[WIDTH-1:1]};
                        cout_q <= c_next;
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboarded bench for serial_adder (WIDTH=8): directed corner cases plus 2000 random back-to-back additions.
module tb_serial_adder;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    logic clk_en;

    serial_adder_if #(.WIDTH(W)) bus ();

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [W:0] expq[$];

    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each done pulse; otherwise the result must hold.
    logic [W:0] held;
    logic       prev_done;
    always @(negedge clk) begin
        if (!rst_n) begin
            held      = '0;
            prev_done = 1'b0;
        end else begin
            if (bus.done) begin
                if (prev_done) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_width: got done high 2 cycles, required 1");
                end
                if (expq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL spurious_done: got done with result 0x%0h, required no done", {bus.cout, bus.sum});
                end else begin
                    held = expq.pop_front();
                    chk("result", 32'({bus.cout, bus.sum}), 32'(held));
                end
            end else begin
                chk("result_hold", 32'({bus.cout, bus.sum}), 32'(held));
            end
            prev_done = bus.done;
        end
    end

    // Called at the negedge right after acceptance (already = RUN cycles already elapsed).
    task automatic wait_done(input string nm, input int already);
        int  busy_cnt = already;
        bit  seen = 0;
        for (int i = 0; i < W + 4 && !seen; i++) begin
            if (bus.done) seen = 1;
            else begin
                if (bus.busy) busy_cnt++;
                @(negedge clk);
            end
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_busy_cycles"}, 32'(busy_cnt), 32'(W));
    endtask

    task automatic op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
        bus.a     = ta;
        bus.b     = tb;
        bus.cin   = tc;
        bus.start = 1'b1;
        expq.push_back({1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc});
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.cin   = 1'($urandom);
        wait_done(nm, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        rst_n     = 1'b1;
        clk_en    = 1'b0;

        // Reset with no clock running.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum",  32'(bus.sum),  32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);

        clk_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op("add_0f_01", 8'h0F, 8'h01, 1'b0);
        @(negedge clk);
        op("add_ff_01", 8'hFF, 8'h01, 1'b0);
        @(negedge clk);
        op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1);

        // Operand changes and start during RUN/DONE must be ignored.
        @(negedge clk);
        bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0; bus.start = 1'b1;
        expq.push_back(9'h046);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'hFF; bus.cin = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("midrun", 2);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_in_done_ignored", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("no_queued_start", 32'(bus.busy), 32'd0);

        // Abort mid-run with reset; aborted op must never produce done.
        bus.a = 8'hAA; bus.b = 8'h55; bus.cin = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_busy_before", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_sum",  32'(bus.sum),  32'd0);
        chk("abort_cout", 32'(bus.cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op("after_abort", 8'hAA, 8'h55, 1'b1);

        for (int c = 0; c < 2; c++) begin
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                op("rand", W'($urandom), W'($urandom), c[0]);
            end
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(expq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
